anabellek_hakemi: RTL and testbench

- Arbitrates the single 128-bit main-memory port between the fetch stage's instruction-cache controller (getir, read-only) and the memory stage's data-cache controller (bellek, read/write).
- Grants one requester at a time and runs exactly one outstanding main-memory transaction.
- Returns the block read, or the write completion, to the granted side as a one-cycle pulse.
- Data side has priority; a starvation counter guarantees fetch progress.

---
 rtl/anabellek_hakemi.sv | 171 +++++++++++++++++
 tb/tb_anabellek_hakemi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anabellek_hakemi.sv
// Main-memory arbiter: shares one 128-bit block port between the fetch-side
// instruction cache (getir) and the data cache (bellek), one transaction at a time.
module anabellek_hakemi #(
  parameter int ACLIK_SINIRI = 4,
  parameter int ZAMAN_ASIMI  = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         getir_istek_i,
  input  logic [31:0]  getir_adres_i,
  input  logic         getir_oku_i,
  output logic         getir_musait_o,
  output logic         getir_veri_hazir_o,
  output logic [127:0] getir_obek_o,

  input  logic         bellek_istek_i,
  input  logic [31:0]  bellek_adres_i,
  input  logic         bellek_oku_i,
  input  logic         bellek_yaz_i,
  input  logic [127:0] bellek_yaz_obek_i,
  output logic         bellek_musait_o,
  output logic         bellek_veri_hazir_o,
  output logic [127:0] bellek_obek_o,

  output logic         ana_istek_o,
  output logic [31:0]  ana_adres_o,
  output logic         ana_oku_o,
  output logic         ana_yaz_o,
  output logic [127:0] ana_yaz_obek_o,
  input  logic         ana_hazir_i,
  input  logic [127:0] ana_obek_i,

  output logic         zaman_asimi_o
);

  localparam int AW = $clog2(ACLIK_SINIRI) + 1;
  localparam int ZW = $clog2(ZAMAN_ASIMI) + 1;
  localparam logic [AW-1:0] ACLIK_UST = AW'(ACLIK_SINIRI);
  localparam logic [ZW-1:0] ZAMAN_UST = ZW'(ZAMAN_ASIMI);

  typedef enum logic [1:0] {
    BOSTA         = 2'd0,
    GETIR_SERVIS  = 2'd1,
    BELLEK_SERVIS = 2'd2,
    TAMAM         = 2'd3
  } durum_t;

  durum_t         durum;
  logic [AW-1:0]  aclik_sayaci;
  logic [ZW-1:0]  zaman_sayaci;
  logic           zaman_asimi;
  logic           ana_istek;
  logic           ana_oku;
  logic           ana_yaz;
  logic [31:0]    ana_adres;
  logic [127:0]   ana_yaz_obek;
  logic [127:0]   getir_obek;
  logic [127:0]   bellek_obek;
  logic           getir_veri_hazir;
  logic           bellek_veri_hazir;

  logic           getir_gecerli;
  logic           bellek_gecerli;
  logic           aclik_doldu;
  logic           getir_kazanir;
  logic           bellek_kazanir;
  logic [ZW-1:0]  zaman_sonraki;

  function automatic logic [AW-1:0] aclik_doygun_artir(input logic [AW-1:0] s);
    return (s >= ACLIK_UST) ? ACLIK_UST : s + AW'(1);
  endfunction

  function automatic logic [ZW-1:0] zaman_doygun_artir(input logic [ZW-1:0] s);
    return (s >= ZAMAN_UST) ? ZAMAN_UST : s + ZW'(1);
  endfunction

  // Data side wins ties unless fetch has already been passed over ACLIK_SINIRI times.
  always_comb begin
    getir_gecerli  = getir_istek_i & getir_oku_i;
    bellek_gecerli = bellek_istek_i & (bellek_oku_i | bellek_yaz_i);
    aclik_doldu    = (aclik_sayaci >= ACLIK_UST);
    getir_kazanir  = getir_gecerli & (~bellek_gecerli | aclik_doldu);
    bellek_kazanir = bellek_gecerli & ~getir_kazanir;
    zaman_sonraki  = zaman_doygun_artir(zaman_sayaci);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum             <= BOSTA;
      aclik_sayaci      <= '0;
      zaman_sayaci      <= '0;
      zaman_asimi       <= 1'b0;
      ana_istek         <= 1'b0;
      ana_oku           <= 1'b0;
      ana_yaz           <= 1'b0;
      ana_adres         <= '0;
      ana_yaz_obek      <= '0;
      getir_obek        <= '0;
      bellek_obek       <= '0;
      getir_veri_hazir  <= 1'b0;
      bellek_veri_hazir <= 1'b0;
    end else begin
      getir_veri_hazir  <= 1'b0;
      bellek_veri_hazir <= 1'b0;
      case (durum)
        BOSTA: begin
          if (getir_kazanir) begin
            durum        <= GETIR_SERVIS;
            ana_istek    <= 1'b1;
            ana_oku      <= 1'b1;
            ana_yaz      <= 1'b0;
            ana_adres    <= getir_adres_i;
            aclik_sayaci <= '0;
            zaman_sayaci <= '0;
          end else if (bellek_kazanir) begin
            durum        <= BELLEK_SERVIS;
            ana_istek    <= 1'b1;
            // A request with both strobes set is treated as a read.
            ana_oku      <= bellek_oku_i;
            ana_yaz      <= ~bellek_oku_i;
            ana_adres    <= bellek_adres_i;
            ana_yaz_obek <= bellek_yaz_obek_i;
            zaman_sayaci <= '0;
            if (getir_gecerli)
              aclik_sayaci <= aclik_doygun_artir(aclik_sayaci);
          end
        end
        GETIR_SERVIS, BELLEK_SERVIS: begin
          zaman_sayaci <= zaman_sonraki;
          if (zaman_sonraki == ZAMAN_UST)
            zaman_asimi <= 1'b1;
          if (ana_hazir_i) begin
            durum     <= TAMAM;
            ana_istek <= 1'b0;
            ana_oku   <= 1'b0;
            ana_yaz   <= 1'b0;
            if (durum == GETIR_SERVIS) begin
              getir_veri_hazir <= 1'b1;
              getir_obek       <= ana_obek_i;
            end else begin
              bellek_veri_hazir <= 1'b1;
              if (ana_oku)
                bellek_obek <= ana_obek_i;
            end
          end
        end
        TAMAM: begin
          durum <= BOSTA;
        end
        default: begin
          durum <= BOSTA;
        end
      endcase
    end
  end

  assign getir_musait_o      = (durum == BOSTA);
  assign bellek_musait_o     = (durum == BOSTA);
  assign getir_veri_hazir_o  = getir_veri_hazir;
  assign bellek_veri_hazir_o = bellek_veri_hazir;
  assign getir_obek_o        = getir_obek;
  assign bellek_obek_o       = bellek_obek;
  assign ana_istek_o         = ana_istek;
  assign ana_adres_o         = ana_adres;
  assign ana_oku_o           = ana_oku;
  assign ana_yaz_o           = ana_yaz;
  assign ana_yaz_obek_o      = ana_yaz_obek;
  assign zaman_asimi_o       = zaman_asimi;

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Directed bench for anabellek_hakemi: table of single transactions plus
// hand-written starvation, timeout, spurious-input and reset sequences.
module tb_anabellek_hakemi;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         getir_istek = 1'b0;
  logic [31:0]  getir_adres = '0;
  logic         getir_oku = 1'b0;
  logic         getir_musait;
  logic         getir_veri_hazir;
  logic [127:0] getir_obek;
  logic         bellek_istek = 1'b0;
  logic [31:0]  bellek_adres = '0;
  logic         bellek_oku = 1'b0;
  logic         bellek_yaz = 1'b0;
  logic [127:0] bellek_yaz_obek = '0;
  logic         bellek_musait;
  logic         bellek_veri_hazir;
  logic [127:0] bellek_obek;
  logic         ana_istek;
  logic [31:0]  ana_adres;
  logic         ana_oku;
  logic         ana_yaz;
  logic [127:0] ana_yaz_obek;
  logic         ana_hazir = 1'b0;
  logic [127:0] ana_obek = '0;
  logic         zaman_asimi;

  anabellek_hakemi #(.ACLIK_SINIRI(4), .ZAMAN_ASIMI(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .getir_istek_i(getir_istek), .getir_adres_i(getir_adres), .getir_oku_i(getir_oku),
    .getir_musait_o(getir_musait), .getir_veri_hazir_o(getir_veri_hazir), .getir_obek_o(getir_obek),
    .bellek_istek_i(bellek_istek), .bellek_adres_i(bellek_adres), .bellek_oku_i(bellek_oku),
    .bellek_yaz_i(bellek_yaz), .bellek_yaz_obek_i(bellek_yaz_obek), .bellek_musait_o(bellek_musait),
    .bellek_veri_hazir_o(bellek_veri_hazir), .bellek_obek_o(bellek_obek),
    .ana_istek_o(ana_istek), .ana_adres_o(ana_adres), .ana_oku_o(ana_oku), .ana_yaz_o(ana_yaz),
    .ana_yaz_obek_o(ana_yaz_obek), .ana_hazir_i(ana_hazir), .ana_obek_i(ana_obek),
    .zaman_asimi_o(zaman_asimi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         gi, go, bi, bo, by;
    logic [31:0]  ga, ba;
    logic [127:0] bw, mo;
    int           gec;
    logic         e_bel, e_oku, e_yaz;
    logic [31:0]  e_adr;
    logic [127:0] e_gob, e_bob;
  } vek_t;

  vek_t tablo [7];
  int n_kontrol = 0;
  int n_hata    = 0;
  localparam logic [127:0] COP = {4{32'hBADB_AD00}};

  task automatic kontrol_b(input string ad, input logic gercek, input logic beklenen);
    n_kontrol++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: actual %b required %b", ad, gercek, beklenen);
    end
  endtask

  task automatic kontrol_v(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
    n_kontrol++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: actual %h required %h", ad, gercek, beklenen);
    end
  endtask

  task automatic istekleri_birak();
    getir_istek = 1'b0; getir_oku = 1'b0; getir_adres = '0;
    bellek_istek = 1'b0; bellek_oku = 1'b0; bellek_yaz = 1'b0;
    bellek_adres = '0; bellek_yaz_obek = '0;
  endtask

  // Called at a falling edge with the arbiter idle.
  task automatic vektor_uygula(input vek_t v, input int i);
    kontrol_b($sformatf("v%0d_getir_musait", i), getir_musait, 1'b1);
    kontrol_b($sformatf("v%0d_bellek_musait", i), bellek_musait, 1'b1);
    getir_istek = v.gi; getir_oku = v.go; getir_adres = v.ga;
    bellek_istek = v.bi; bellek_oku = v.bo; bellek_yaz = v.by;
    bellek_adres = v.ba; bellek_yaz_obek = v.bw;
    @(negedge clk);
    kontrol_b($sformatf("v%0d_ana_istek", i), ana_istek, 1'b1);
    kontrol_b($sformatf("v%0d_ana_oku", i), ana_oku, v.e_oku);
    kontrol_b($sformatf("v%0d_ana_yaz", i), ana_yaz, v.e_yaz);
    kontrol_v($sformatf("v%0d_ana_adres", i), 128'(ana_adres), 128'(v.e_adr));
    if (v.e_yaz)
      kontrol_v($sformatf("v%0d_ana_yaz_obek", i), ana_yaz_obek, v.bw);
    kontrol_b($sformatf("v%0d_musait_busy", i), getir_musait, 1'b0);
    getir_adres = 32'hFFFF_FFF0;
    bellek_adres = 32'hFFFF_FFF0;
    repeat (v.gec - 1) @(negedge clk);
    kontrol_b($sformatf("v%0d_ana_istek_held", i), ana_istek, 1'b1);
    kontrol_v($sformatf("v%0d_ana_adres_held", i), 128'(ana_adres), 128'(v.e_adr));
    ana_hazir = 1'b1; ana_obek = v.mo;
    @(negedge clk);
    ana_hazir = 1'b0; ana_obek = COP;
    kontrol_b($sformatf("v%0d_getir_pulse", i), getir_veri_hazir, ~v.e_bel);
    kontrol_b($sformatf("v%0d_bellek_pulse", i), bellek_veri_hazir, v.e_bel);
    kontrol_b($sformatf("v%0d_ana_istek_tamam", i), ana_istek, 1'b0);
    kontrol_v($sformatf("v%0d_getir_obek", i), getir_obek, v.e_gob);
    kontrol_v($sformatf("v%0d_bellek_obek", i), bellek_obek, v.e_bob);
    istekleri_birak();
    @(negedge clk);
    kontrol_b($sformatf("v%0d_getir_pulse_end", i), getir_veri_hazir, 1'b0);
    kontrol_b($sformatf("v%0d_bellek_pulse_end", i), bellek_veri_hazir, 1'b0);
    kontrol_b($sformatf("v%0d_musait_idle", i), bellek_musait, 1'b1);
    kontrol_v($sformatf("v%0d_getir_obek_keep", i), getir_obek, v.e_gob);
    kontrol_v($sformatf("v%0d_bellek_obek_keep", i), bellek_obek, v.e_bob);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tablo[0] = '{default: '0, gi: 1'b1, go: 1'b1, ga: 32'h0000_1000, mo: {8{16'hAAAA}}, gec: 5,
                 e_bel: 1'b0, e_oku: 1'b1, e_adr: 32'h0000_1000, e_gob: {8{16'hAAAA}}};
    tablo[1] = '{default: '0, bi: 1'b1, by: 1'b1, ba: 32'h0000_2000, bw: {8{16'h1234}},
                 mo: {4{32'hDEAD_BEEF}}, gec: 3, e_bel: 1'b1, e_yaz: 1'b1, e_adr: 32'h0000_2000,
                 e_gob: {8{16'hAAAA}}, e_bob: '0};
    tablo[2] = '{default: '0, bi: 1'b1, bo: 1'b1, ba: 32'h0000_3000, mo: {4{32'h5555_0001}}, gec: 1,
                 e_bel: 1'b1, e_oku: 1'b1, e_adr: 32'h0000_3000, e_gob: {8{16'hAAAA}},
                 e_bob: {4{32'h5555_0001}}};
    tablo[3] = '{default: '0, bi: 1'b1, bo: 1'b1, by: 1'b1, ba: 32'h0000_4000, bw: {4{32'hFFFF_0000}},
                 mo: {4{32'hC0DE_0002}}, gec: 2, e_bel: 1'b1, e_oku: 1'b1, e_adr: 32'h0000_4000,
                 e_gob: {8{16'hAAAA}}, e_bob: {4{32'hC0DE_0002}}};
    tablo[4] = '{default: '0, gi: 1'b1, go: 1'b1, ga: 32'h0000_4400, bi: 1'b1, by: 1'b1,
                 ba: 32'h0000_5000, bw: {4{32'h0BAD_F00D}}, mo: {4{32'h1111_1111}}, gec: 2,
                 e_bel: 1'b1, e_yaz: 1'b1, e_adr: 32'h0000_5000, e_gob: {8{16'hAAAA}},
                 e_bob: {4{32'hC0DE_0002}}};
    tablo[5] = '{default: '0, gi: 1'b1, go: 1'b1, ga: 32'h0000_6000, bi: 1'b1, ba: 32'h0000_6100,
                 mo: {4{32'h7777_8888}}, gec: 2, e_bel: 1'b0, e_oku: 1'b1, e_adr: 32'h0000_6000,
                 e_gob: {4{32'h7777_8888}}, e_bob: {4{32'hC0DE_0002}}};
    tablo[6] = '{default: '0, gi: 1'b1, go: 1'b0, ga: 32'h0000_6600, bi: 1'b1, bo: 1'b1,
                 ba: 32'h0000_7000, mo: {4{32'h2468_ACE0}}, gec: 1, e_bel: 1'b1, e_oku: 1'b1,
                 e_adr: 32'h0000_7000, e_gob: {4{32'h7777_8888}}, e_bob: {4{32'h2468_ACE0}}};

    // Power-on reset with a request present: arbiter must stay idle.
    getir_istek = 1'b1; getir_oku = 1'b1; getir_adres = 32'h0000_0040;
    @(negedge clk);
    kontrol_b("rst_ana_istek", ana_istek, 1'b0);
    kontrol_b("rst_getir_musait", getir_musait, 1'b1);
    kontrol_b("rst_bellek_musait", bellek_musait, 1'b1);
    kontrol_b("rst_zaman_asimi", zaman_asimi, 1'b0);
    kontrol_v("rst_getir_obek", getir_obek, '0);
    kontrol_v("rst_ana_adres", 128'(ana_adres), '0);
    istekleri_birak();
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      vektor_uygula(tablo[i], i);

    // Spurious completion while idle.
    ana_hazir = 1'b1; ana_obek = COP;
    @(negedge clk);
    ana_hazir = 1'b0;
    kontrol_b("spur_getir_pulse", getir_veri_hazir, 1'b0);
    kontrol_b("spur_bellek_pulse", bellek_veri_hazir, 1'b0);
    kontrol_b("spur_musait", getir_musait, 1'b1);
    kontrol_b("spur_ana_istek", ana_istek, 1'b0);
    kontrol_v("spur_bellek_obek", bellek_obek, {4{32'h2468_ACE0}});

    // Starvation: both sides held, data side re-requesting back to back.
    getir_istek = 1'b1; getir_oku = 1'b1; getir_adres = 32'h0000_0100;
    bellek_istek = 1'b1; bellek_oku = 1'b1; bellek_adres = 32'h0000_0200;
    for (int k = 0; k < 5; k++) begin
      int bekle;
      bekle = 0;
      @(negedge clk);
      while (!ana_istek && bekle < 10) begin
        @(negedge clk);
        bekle++;
      end
      kontrol_b($sformatf("aclik_g%0d_started", k), ana_istek, 1'b1);
      kontrol_v($sformatf("aclik_g%0d_adres", k), 128'(ana_adres), (k < 4) ? 128'h200 : 128'h100);
      kontrol_v($sformatf("aclik_g%0d_sayac", k), 128'(dut.aclik_sayaci), (k < 4) ? 128'(k + 1) : '0);
      ana_hazir = 1'b1; ana_obek = {4{32'(k)}};
      @(negedge clk);
      ana_hazir = 1'b0;
      kontrol_b($sformatf("aclik_g%0d_getir_pulse", k), getir_veri_hazir, (k == 4));
      kontrol_b($sformatf("aclik_g%0d_bellek_pulse", k), bellek_veri_hazir, (k < 4));
      if (k == 4) istekleri_birak();
    end
    @(negedge clk);

    // Timeout with completion withheld.
    bellek_istek = 1'b1; bellek_yaz = 1'b1; bellek_adres = 32'h0000_9000;
    @(negedge clk);
    repeat (15) @(negedge clk);
    kontrol_b("tmo_before", zaman_asimi, 1'b0);
    @(negedge clk);
    kontrol_b("tmo_rise", zaman_asimi, 1'b1);
    kontrol_b("tmo_still_waiting", ana_istek, 1'b1);
    ana_hazir = 1'b1;
    @(negedge clk);
    ana_hazir = 1'b0;
    kontrol_b("tmo_bellek_pulse", bellek_veri_hazir, 1'b1);
    istekleri_birak();
    @(negedge clk);
    kontrol_b("tmo_sticky", zaman_asimi, 1'b1);

    // Reset two cycles into a fetch read.
    getir_istek = 1'b1; getir_oku = 1'b1; getir_adres = 32'h0000_A000;
    @(negedge clk);
    kontrol_b("mid_ana_istek_up", ana_istek, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    kontrol_b("mid_ana_istek", ana_istek, 1'b0);
    kontrol_b("mid_ana_oku", ana_oku, 1'b0);
    kontrol_b("mid_getir_musait", getir_musait, 1'b1);
    kontrol_b("mid_bellek_musait", bellek_musait, 1'b1);
    kontrol_b("mid_zaman_asimi", zaman_asimi, 1'b0);
    kontrol_v("mid_bellek_obek", bellek_obek, '0);
    kontrol_v("mid_ana_adres", 128'(ana_adres), '0);
    istekleri_birak();
    @(negedge clk);
    rst = 1'b1;
    ana_hazir = 1'b1; ana_obek = COP;
    @(negedge clk);
    ana_hazir = 1'b0;
    kontrol_b("late_getir_pulse", getir_veri_hazir, 1'b0);
    kontrol_b("late_bellek_pulse", bellek_veri_hazir, 1'b0);
    kontrol_b("late_musait", getir_musait, 1'b1);
    kontrol_v("late_getir_obek", getir_obek, '0);
    @(negedge clk);
    kontrol_b("late_getir_pulse2", getir_veri_hazir, 1'b0);
    kontrol_b("late_musait2", bellek_musait, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule
